// File: rtl/floating_point_subtraction_seq_if.sv
// Handshake and data bundle for the sequential single-precision subtractor.
//
// Upstream side : valid_in / ready_out carry floating1_in and floating2_in.
// Downstream side: valid_out / ready_in carry floating_subtraction_out.
// A transfer happens on a rising edge where valid and ready are both 1.
// A source holds its data stable while valid is 1 and ready is 0.
// Ready never depends combinationally on valid.
//
// busy_out  : FSM is not in IDLE.
// state_dbg : raw FSM state encoding, for checkers and debug.
//
// Modports:
//   slave  : the subtractor itself.
//   master : the environment around it, which drives operands and accepts results.
interface floating_point_subtraction_seq_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  valid_in;
  logic                  ready_out;
  logic [DATA_WIDTH-1:0] floating1_in;
  logic [DATA_WIDTH-1:0] floating2_in;
  logic                  valid_out;
  logic                  ready_in;
  logic [DATA_WIDTH-1:0] floating_subtraction_out;
  logic                  busy_out;
  logic [2:0]            state_dbg;

  modport slave (
    input  valid_in, floating1_in, floating2_in, ready_in,
    output ready_out, valid_out, floating_subtraction_out, busy_out, state_dbg
  );

  modport master (
    output valid_in, floating1_in, floating2_in, ready_in,
    input  ready_out, valid_out, floating_subtraction_out, busy_out, state_dbg
  );
endinterface

// File: rtl/floating_point_subtraction_seq.sv
// Multi-cycle IEEE-754 single-precision subtractor: result = floating1_in - floating2_in.
//
// Ports:
//   clk_in   : clock, rising edge
//   rst_n_in : asynchronous active-low reset
//   bus      : floating_point_subtraction_seq_if.slave
//              (operand handshake, result handshake, busy_out, state_dbg)
//
// Flow: IDLE -> UNPACK -> ALIGN -> SUB -> NORM -> ROUND -> DONE -> IDLE.
// ALIGN and NORM move one bit per cycle. NaN, infinity and zero operands
// resolve in UNPACK and go straight to DONE. Denormals are flushed to zero.
//
// Working significand layout, SIG_W = MENT_WIDTH+5 bits:
//   [SIG_W-1]  carry out of the magnitude add
//   [SIG_W-2]  hidden one
//   [..3]      stored mantissa
//   [2]        guard
//   [1]        round
//   [0]        sticky
module floating_point_subtraction_seq #(
  parameter int DATA_WIDTH = 32,
  parameter int MENT_WIDTH = 23,
  parameter int EXPO_WIDTH = 8
) (
  input  logic                           clk_in,
  input  logic                           rst_n_in,
  floating_point_subtraction_seq_if.slave bus
);

  localparam int SIG_W = MENT_WIDTH + 5;
  localparam logic [EXPO_WIDTH-1:0] EXP_ONES = {EXPO_WIDTH{1'b1}};
  localparam logic [EXPO_WIDTH:0]   EXP_INF  = {1'b0, {EXPO_WIDTH{1'b1}}};
  localparam logic [EXPO_WIDTH-1:0] DIFF_MAX = EXPO_WIDTH'(MENT_WIDTH + 3);
  localparam logic [DATA_WIDTH-1:0] QNAN =
    {1'b0, {EXPO_WIDTH{1'b1}}, 1'b1, {(MENT_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_UNPACK = 3'd1,
    S_ALIGN  = 3'd2,
    S_SUB    = 3'd3,
    S_NORM   = 3'd4,
    S_ROUND  = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  state_t state_q, state_d;

  logic [DATA_WIDTH-1:0] op1_q, op1_d, op2_q, op2_d;
  logic [SIG_W-1:0]      sig_a_q, sig_a_d, sig_b_q, sig_b_d;
  logic [EXPO_WIDTH:0]   exp_q, exp_d;     // one spare bit for round overflow
  logic [EXPO_WIDTH-1:0] diff_q, diff_d;
  logic                  sign_q, sign_d;
  logic                  eff_sub_q, eff_sub_d;
  logic [DATA_WIDTH-1:0] res_q, res_d;

  // Field decode of the captured operands; op2 sign is inverted so the
  // rest of the datapath only ever adds a + (-b).
  logic                  s1_w, s2_w;
  logic [EXPO_WIDTH-1:0] e1_w, e2_w;
  logic [MENT_WIDTH-1:0] m1_w, m2_w;
  logic                  nan1_w, nan2_w, inf1_w, inf2_w, zero1_w, zero2_w;
  logic                  special_w, a_big_w;
  logic [DATA_WIDTH-1:0] special_res_w;

  always_comb begin
    s1_w    = op1_q[DATA_WIDTH-1];
    e1_w    = op1_q[DATA_WIDTH-2 -: EXPO_WIDTH];
    m1_w    = op1_q[MENT_WIDTH-1:0];
    s2_w    = ~op2_q[DATA_WIDTH-1];
    e2_w    = op2_q[DATA_WIDTH-2 -: EXPO_WIDTH];
    m2_w    = op2_q[MENT_WIDTH-1:0];
    nan1_w  = (e1_w == EXP_ONES) && (m1_w != '0);
    nan2_w  = (e2_w == EXP_ONES) && (m2_w != '0);
    inf1_w  = (e1_w == EXP_ONES) && (m1_w == '0);
    inf2_w  = (e2_w == EXP_ONES) && (m2_w == '0);
    zero1_w = (e1_w == '0);
    zero2_w = (e2_w == '0);
    a_big_w = ({e1_w, m1_w} >= {e2_w, m2_w});

    special_w     = 1'b1;
    special_res_w = QNAN;
    if (nan1_w || nan2_w) begin
      special_res_w = QNAN;
    end else if (inf1_w && inf2_w) begin
      // Opposite effective signs means inf - inf of the same original sign.
      special_res_w = (s1_w != s2_w) ? QNAN : {s1_w, EXP_ONES, {MENT_WIDTH{1'b0}}};
    end else if (inf1_w) begin
      special_res_w = {s1_w, EXP_ONES, {MENT_WIDTH{1'b0}}};
    end else if (inf2_w) begin
      special_res_w = {s2_w, EXP_ONES, {MENT_WIDTH{1'b0}}};
    end else if (zero1_w && zero2_w) begin
      special_res_w = {s1_w & s2_w, {(DATA_WIDTH-1){1'b0}}};
    end else if (zero1_w) begin
      special_res_w = {s2_w, op2_q[DATA_WIDTH-2:0]};
    end else if (zero2_w) begin
      special_res_w = {s1_w, op1_q[DATA_WIDTH-2:0]};
    end else begin
      special_w     = 1'b0;
      special_res_w = '0;
    end
  end

  // Arithmetic helpers for SUB / NORM / ROUND.
  logic [SIG_W-1:0]      sum_w;
  logic                  carry_w, hidden_w, rnd_inc_w;
  logic [MENT_WIDTH+1:0] mant_rnd_w;
  logic [EXPO_WIDTH:0]   exp_rnd_w;
  logic [MENT_WIDTH-1:0] mant_field_w;
  logic [DATA_WIDTH-1:0] round_res_w;

  always_comb begin
    // A has the larger magnitude, so A - B never goes negative.
    sum_w     = eff_sub_q ? (sig_a_q - sig_b_q) : (sig_a_q + sig_b_q);
    carry_w   = sig_a_q[SIG_W-1];
    hidden_w  = sig_a_q[SIG_W-2];
    // Nearest-even: round up when G and any of R, S or the kept lsb.
    rnd_inc_w = sig_a_q[2] & (sig_a_q[1] | sig_a_q[0] | sig_a_q[3]);
    mant_rnd_w = {1'b0, sig_a_q[SIG_W-2:3]} + {{(MENT_WIDTH+1){1'b0}}, rnd_inc_w};
    exp_rnd_w  = exp_q + {{EXPO_WIDTH{1'b0}}, mant_rnd_w[MENT_WIDTH+1]};
    mant_field_w = mant_rnd_w[MENT_WIDTH+1] ? mant_rnd_w[MENT_WIDTH:1]
                                            : mant_rnd_w[MENT_WIDTH-1:0];
    if (exp_rnd_w >= EXP_INF) begin
      round_res_w = {sign_q, EXP_ONES, {MENT_WIDTH{1'b0}}};
    end else begin
      round_res_w = {sign_q, exp_rnd_w[EXPO_WIDTH-1:0], mant_field_w};
    end
  end

  // State register.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (bus.valid_in) state_d = S_UNPACK;
      S_UNPACK: state_d = special_w ? S_DONE : S_ALIGN;
      S_ALIGN:  if (diff_q == '0) state_d = S_SUB;
      S_SUB:    state_d = (sum_w == '0) ? S_DONE : S_NORM;
      S_NORM: begin
        if (carry_w)                               state_d = S_NORM;
        else if (hidden_w)                         state_d = S_ROUND;
        else if (exp_q <= (EXPO_WIDTH+1)'(1))      state_d = S_DONE;
        else                                       state_d = S_NORM;
      end
      S_ROUND:  state_d = S_DONE;
      S_DONE:   if (bus.ready_in) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state only.
  always_comb begin
    bus.ready_out                = (state_q == S_IDLE);
    bus.valid_out                = (state_q == S_DONE);
    bus.busy_out                 = (state_q != S_IDLE);
    bus.floating_subtraction_out = res_q;
    bus.state_dbg                = state_q;
  end

  // Datapath next values.
  always_comb begin
    op1_d     = op1_q;
    op2_d     = op2_q;
    sig_a_d   = sig_a_q;
    sig_b_d   = sig_b_q;
    exp_d     = exp_q;
    diff_d    = diff_q;
    sign_d    = sign_q;
    eff_sub_d = eff_sub_q;
    res_d     = res_q;
    case (state_q)
      S_IDLE: begin
        if (bus.valid_in) begin
          op1_d = bus.floating1_in;
          op2_d = bus.floating2_in;
        end
      end
      S_UNPACK: begin
        if (special_w) begin
          res_d = special_res_w;
        end else begin
          eff_sub_d = s1_w ^ s2_w;
          if (a_big_w) begin
            sign_d  = s1_w;
            exp_d   = {1'b0, e1_w};
            diff_d  = e1_w - e2_w;
            sig_a_d = {2'b01, m1_w, 3'b000};
            sig_b_d = {2'b01, m2_w, 3'b000};
          end else begin
            sign_d  = s2_w;
            exp_d   = {1'b0, e2_w};
            diff_d  = e2_w - e1_w;
            sig_a_d = {2'b01, m2_w, 3'b000};
            sig_b_d = {2'b01, m1_w, 3'b000};
          end
        end
      end
      S_ALIGN: begin
        if (diff_q > DIFF_MAX) begin
          // Everything would be shifted out: keep only the sticky.
          sig_b_d = {{(SIG_W-1){1'b0}}, |sig_b_q};
          diff_d  = '0;
        end else if (diff_q != '0) begin
          sig_b_d = {1'b0, sig_b_q[SIG_W-1:2], sig_b_q[1] | sig_b_q[0]};
          diff_d  = diff_q - EXPO_WIDTH'(1);
        end
      end
      S_SUB: begin
        if (sum_w == '0) begin
          res_d = '0;
        end else begin
          sig_a_d = sum_w;
        end
      end
      S_NORM: begin
        if (carry_w) begin
          sig_a_d = {1'b0, sig_a_q[SIG_W-1:2], sig_a_q[1] | sig_a_q[0]};
          exp_d   = exp_q + (EXPO_WIDTH+1)'(1);
        end else if (!hidden_w) begin
          if (exp_q <= (EXPO_WIDTH+1)'(1)) begin
            // Would become denormal: flush to signed zero.
            res_d = {sign_q, {(DATA_WIDTH-1){1'b0}}};
          end else begin
            sig_a_d = sig_a_q << 1;
            exp_d   = exp_q - (EXPO_WIDTH+1)'(1);
          end
        end
      end
      S_ROUND: res_d = round_res_w;
      default: ;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      op1_q     <= '0;
      op2_q     <= '0;
      sig_a_q   <= '0;
      sig_b_q   <= '0;
      exp_q     <= '0;
      diff_q    <= '0;
      sign_q    <= 1'b0;
      eff_sub_q <= 1'b0;
      res_q     <= '0;
    end else begin
      op1_q     <= op1_d;
      op2_q     <= op2_d;
      sig_a_q   <= sig_a_d;
      sig_b_q   <= sig_b_d;
      exp_q     <= exp_d;
      diff_q    <= diff_d;
      sign_q    <= sign_d;
      eff_sub_q <= eff_sub_d;
      res_q     <= res_d;
    end
  end

endmodule

// File: tb/tb_floating_point_subtraction_seq.sv
// Directed bench for floating_point_subtraction_seq: expected results are
// queued when operands are accepted and compared when valid_out appears.
module tb_floating_point_subtraction_seq;

  logic clk_in;
  logic rst_n_in;

  floating_point_subtraction_seq_if #(.DATA_WIDTH(32)) bus ();

  floating_point_subtraction_seq #(
    .DATA_WIDTH(32), .MENT_WIDTH(23), .EXPO_WIDTH(8)
  ) dut (
    .clk_in  (clk_in),
    .rst_n_in(rst_n_in),
    .bus     (bus.slave)
  );

  // Clock / watchdog
  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard
  logic [31:0] exp_q[$];
  int          errors = 0;
  int          checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Driver tasks
  task automatic accept(input logic [31:0] a, input logic [31:0] b, input logic [31:0] expv);
    check("ready_before_accept", {31'b0, bus.ready_out}, 32'd1);
    bus.floating1_in = a;
    bus.floating2_in = b;
    bus.valid_in     = 1'b1;
    @(posedge clk_in); #1;
    bus.valid_in = 1'b0;
    exp_q.push_back(expv);
  endtask

  // Waits for valid_out, checks latency (if exp_lat >= 0) and the result.
  task automatic wait_result(input string tag, input int exp_lat);
    int          lat;
    logic [31:0] expv;
    lat = 0;
    while (bus.valid_out !== 1'b1 && lat < 100) begin
      @(posedge clk_in); #1;
      lat++;
    end
    check({tag, "_valid"}, {31'b0, bus.valid_out}, 32'd1);
    if (exp_lat >= 0) check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_ready_low"}, {31'b0, bus.ready_out}, 32'd0);
    if (exp_q.size() == 0) begin
      check({tag, "_queue_nonempty"}, 32'd0, 32'd1);
    end else begin
      expv = exp_q.pop_front();
      check({tag, "_out"}, bus.floating_subtraction_out, expv);
    end
  endtask

  task automatic transfer(input string tag, input logic [31:0] held);
    bus.ready_in = 1'b1;
    @(posedge clk_in); #1;
    bus.ready_in = 1'b0;
    check({tag, "_valid_drop"}, {31'b0, bus.valid_out}, 32'd0);
    check({tag, "_ready_back"}, {31'b0, bus.ready_out}, 32'd1);
    check({tag, "_out_kept"}, bus.floating_subtraction_out, held);
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] expv, input int exp_lat);
    accept(a, b, expv);
    wait_result(tag, exp_lat);
    transfer(tag, expv);
  endtask

  // Directed sequence
  initial begin
    rst_n_in         = 1'b0;
    bus.valid_in     = 1'b0;
    bus.ready_in     = 1'b0;
    bus.floating1_in = '0;
    bus.floating2_in = '0;
    #1;
    check("rst_ready", {31'b0, bus.ready_out}, 32'd1);
    check("rst_valid", {31'b0, bus.valid_out}, 32'd0);
    check("rst_busy",  {31'b0, bus.busy_out},  32'd0);
    check("rst_out",   bus.floating_subtraction_out, 32'h0);
    repeat (2) @(posedge clk_in);
    #1 rst_n_in = 1'b1;
    @(posedge clk_in); #1;

    run_op("three_minus_one", 32'h40400000, 32'h3F800000, 32'h40000000, 6);
    run_op("norm_two",        32'h3FC00000, 32'h3FA00000, 32'h3E800000, 7);
    run_op("exact_zero",      32'h3F800000, 32'h3F800000, 32'h00000000, -1);
    run_op("one_minus_neg",   32'h3F800000, 32'hBF800000, 32'h40000000, 6);
    run_op("collapse",        32'h3F800000, 32'h30800000, 32'h3F800000, -1);
    run_op("inf_minus_inf",   32'h7F800000, 32'h7F800000, 32'h7FC00000, -1);
    run_op("neg_sum",         32'hC0000000, 32'h40000000, 32'hC0800000, -1);
    run_op("nan_in",          32'h7F800001, 32'h3F800000, 32'h7FC00000, -1);
    run_op("single_inf",      32'h3F800000, 32'h7F800000, 32'hFF800000, -1);
    run_op("neg_zero",        32'h80000000, 32'h00000000, 32'h80000000, -1);
    run_op("zero_minus_x",    32'h00000000, 32'h40400000, 32'hC0400000, -1);
    run_op("overflow",        32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7F800000, -1);
    run_op("underflow_flush", 32'h00800001, 32'h00800000, 32'h00000000, -1);

    // Back-pressure: hold ready_in low in DONE while pulsing valid_in.
    accept(32'h3FC00000, 32'h3FA00000, 32'h3E800000);
    wait_result("hold", 7);
    for (int i = 0; i < 10; i++) begin
      bus.valid_in     = 1'($urandom_range(0, 1));
      bus.floating1_in = 32'($urandom_range(0, 32'h7FFFFFFF));
      bus.floating2_in = 32'($urandom_range(0, 32'h7FFFFFFF));
      @(posedge clk_in); #1;
      check("hold_valid", {31'b0, bus.valid_out}, 32'd1);
      check("hold_out",   bus.floating_subtraction_out, 32'h3E800000);
      check("hold_ready", {31'b0, bus.ready_out}, 32'd0);
    end
    bus.valid_in = 1'b0;
    transfer("hold", 32'h3E800000);
    @(posedge clk_in); #1;
    check("hold_idle_after", {31'b0, bus.busy_out}, 32'd0);

    // Reset in the middle of ALIGN (diff = 7).
    bus.floating1_in = 32'h3F800000;
    bus.floating2_in = 32'h3C000000;
    bus.valid_in     = 1'b1;
    @(posedge clk_in); #1;
    bus.valid_in = 1'b0;
    @(posedge clk_in); #1;
    check("mid_state_align", {29'b0, bus.state_dbg}, 32'd2);
    rst_n_in = 1'b0;
    #1;
    check("mid_rst_valid", {31'b0, bus.valid_out}, 32'd0);
    check("mid_rst_ready", {31'b0, bus.ready_out}, 32'd1);
    check("mid_rst_busy",  {31'b0, bus.busy_out},  32'd0);
    check("mid_rst_out",   bus.floating_subtraction_out, 32'h0);
    @(posedge clk_in); #1;
    rst_n_in = 1'b1;
    @(posedge clk_in); #1;
    run_op("after_reset", 32'h3F800000, 32'h3C000000, 32'h3F7E0000, 13);

    check("queue_empty", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/floating_point_subtraction_seq.md
Name: floating_point_subtraction_seq

Overview:
Multi-cycle IEEE-754 single-precision subtractor computing floating1_in - floating2_in. It reuses the team's sign/exponent/mantissa field split, with a valid/ready handshake on both sides. An FSM replaces the combinational exponent-compare/mux/control loop with sequential align, subtract, normalize and round steps, one bit of shift per cycle. It sits beside floating_point_addition in the FPU datapath and serves as the registered, back-pressurable arithmetic unit.

Parameters:
DATA_WIDTH, 32, total operand/result width
MENT_WIDTH, 23, stored mantissa bits
EXPO_WIDTH, 8, exponent bits (bias = 2^(EXPO_WIDTH-1)-1 = 127)

Ports:
clk_in  input  1  clock, rising edge
rst_n_in  input  1  asynchronous active-low reset
valid_in  input  1  operands valid
ready_out  output  1  block can accept operands
floating1_in  input  DATA_WIDTH  minuend
floating2_in  input  DATA_WIDTH  subtrahend
valid_out  output  1  result valid
ready_in  input  1  downstream accepts result
floating_subtraction_out  output  DATA_WIDTH  result
busy_out  output  1  FSM not in IDLE

Behaviour:
- Reset (async, rst_n_in=0): state=IDLE; ready_out=1, valid_out=0, busy_out=0, floating_subtraction_out=0; all internal registers cleared. Reset mid-operation discards the operation in flight; no partial result is ever emitted.
- Accept: valid_in & ready_out on a rising edge captures both operands. ready_out=1 only in IDLE.
- States: IDLE -> UNPACK -> ALIGN -> SUB -> NORM -> ROUND -> DONE -> IDLE.
- UNPACK (1 cycle):
  - Invert sign2 (a-b = a+(-b)).
  - Exponent 0 means zero; denormals are flushed to signed zero.
  - Build 24-bit significands with the hidden 1, plus 3 extra bits G/R/S.
  - Swap operands so that op A has the larger magnitude (exponent, then mantissa).
  - Special cases go directly to DONE:
    - any NaN -> 0x7FC00000
    - inf - inf of same sign -> 0x7FC00000
    - single inf -> that inf with its effective sign
    - both zero -> +0 unless both effective signs are negative (-0)
    - one zero -> the other operand with its effective sign
- ALIGN: shift B right 1 bit per cycle, decrementing diff, with sticky = OR of all bits shifted out. If diff > MENT_WIDTH+3, B collapses in one cycle to S=1 (if B nonzero) and diff=0. Duration is min(diff, 1) to 26 cycles; 0 cycles of shifting if diff=0 (a single pass-through cycle).
- SUB (1 cycle): 28-bit magnitude add if effective signs are equal, else A-B. Result sign = sign of A. An exact-zero result gives +0 and goes to DONE.
- NORM:
  - Carry-out: shift right 1 (preserving sticky), exp+1, in 1 cycle.
  - Otherwise shift left 1 bit per cycle until bit 26 = 1, exp-1 each cycle.
  - If exp reaches 0 while shifting, flush to signed zero.
- ROUND (1 cycle): round to nearest, ties to even, on G/R/S. A mantissa overflow renormalizes with exp+1. If exp >= 255, the result is inf with the result sign.
- DONE: valid_out=1 and the result is held stable until ready_in=1. Transfer happens on valid_out & ready_in; the next cycle gives IDLE with valid_out=0.
  - ready_out stays 0 throughout DONE, so there is no overlap of a new accept with a pending result.
  - floating_subtraction_out keeps its last value after transfer.
- Latency (accept to valid_out): 5 + align_cycles + norm_cycles. Example: equal exponents with no normalization shift gives 5 cycles.
- busy_out = (state != IDLE).
- valid_in during busy is ignored; the operands are not captured.

Test Plan:
- Reset high, accept 0x40400000 - 0x3F800000 (3.0-1.0) -> valid_out after 6 cycles (1 align cycle, 0 norm), out=0x40000000.
- 0x3FC00000 - 0x3FA00000 (1.5-1.25) -> 2 norm shift cycles, out=0x3E800000.
- 0x3F800000 - 0x3F800000 -> out=0x00000000; 0x3F800000 - 0xBF800000 -> 0x40000000.
- 0x3F800000 - 0x30800000 (1.0-2^-30) -> alignment collapse, sticky set, rounds to 0x3F800000; 0x7F800000 - 0x7F800000 -> 0x7FC00000.
- Hold ready_in=0 for 10 cycles in DONE -> valid_out and output stable, ready_out=0, valid_in pulses ignored; ready_in=1 -> transfer, then IDLE with ready_out=1.
- Assert rst_n_in during ALIGN -> immediate IDLE, valid_out=0; the next operation completes correctly.
